// File: rtl/memory_unit_pkg.sv
// -----------------------------------------------------------------------------
// memory_unit_pkg
//   Shared definitions for the 8-bit processor memory path.
//   - ADDR_W_DEF / DATA_W_DEF : default address and word widths
//   - RW_READ / RW_WRITE      : encoding of the read/write strobe, shared with
//                               the control unit so both sides agree on polarity
// -----------------------------------------------------------------------------
package memory_unit_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 8;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage : memory_unit_pkg

// File: rtl/memory_unit.sv
// -----------------------------------------------------------------------------
// memory_unit
//   Single-port synchronous RAM (DEPTH x DATA_W) built from flops so the whole
//   array can be cleared by the asynchronous reset.
//
//   Ports:
//     clk          : system clock, all state changes on the rising edge
//     rst_n        : asynchronous active-low reset, clears array and output
//     address_bus  : word address shared by read and write
//     mem_enable   : access enable, 0 = idle (everything holds)
//     read_write   : 1 = read, 0 = write (sampled only when enabled)
//     data_bus_in  : write data
//     data_bus_out : registered read data, one clock of latency
// -----------------------------------------------------------------------------
module memory_unit
    import memory_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address_bus,
    input  logic              mem_enable,
    input  logic              read_write,
    input  logic [DATA_W-1:0] data_bus_in,
    output logic [DATA_W-1:0] data_bus_out
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] dout_d;
    logic              wr_en;

    assign wr_en = mem_enable && (read_write == RW_WRITE);

    // Output register only reloads on an enabled read; writes and idle hold it.
    always_comb begin
        dout_d = dout_q;
        if (mem_enable && (read_write == RW_READ)) begin
            dout_d = mem_q[address_bus];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            dout_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[address_bus] <= data_bus_in;
            end
            dout_q <= dout_d;
        end
    end

    assign data_bus_out = dout_q;

endmodule : memory_unit

// File: tb/tb_memory_unit.sv
// -----------------------------------------------------------------------------
// tb_memory_unit
//   Directed test of memory_unit with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_memory_unit;

    logic       clk;
    logic       rst_n;
    logic [3:0] address_bus;
    logic       mem_enable;
    logic       read_write;
    logic [7:0] data_bus_in;
    logic [7:0] data_bus_out;

    int unsigned n_cmp;
    int unsigned n_bad;

    memory_unit #(
        .ADDR_W(4),
        .DATA_W(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .address_bus (address_bus),
        .mem_enable  (mem_enable),
        .read_write  (read_write),
        .data_bus_in (data_bus_in),
        .data_bus_out(data_bus_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, step past the next rising edge, sample at +1.
    task automatic op(input logic en, input logic rw, input logic [3:0] a, input logic [7:0] d);
        mem_enable  = en;
        read_write  = rw;
        address_bus = a;
        data_bus_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        mem_enable = 1'b0;
        read_write = 1'b1;
        address_bus = '0;
        data_bus_in = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", data_bus_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Load a non-zero value so the asynchronous clear is observable.
        op(1'b1, 1'b0, 4'd1, 8'h5A);
        op(1'b1, 1'b1, 4'd1, 8'h00);
        chk("preload_read", data_bus_out, 8'h5A);

        // Reset mid-cycle: output must clear without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out", data_bus_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        for (int i = 0; i < 16; i++) begin
            op(1'b1, 1'b1, 4'(i), 8'hFF);
            chk($sformatf("post_reset_rd%0d", i), data_bus_out, 8'h00);
        end

        op(1'b1, 1'b1, 4'd5, 8'h00);
        chk("read_after_reset", data_bus_out, 8'h00);

        op(1'b1, 1'b0, 4'd5, 8'h0F);
        chk("write_holds_out", data_bus_out, 8'h00);
        op(1'b1, 1'b1, 4'd5, 8'h00);
        chk("readback_5", data_bus_out, 8'h0F);

        op(1'b1, 1'b0, 4'd3, 8'hA5);
        chk("write3_holds_out", data_bus_out, 8'h0F);
        op(1'b0, 1'b0, 4'd3, 8'h11);
        chk("idle_hold_1", data_bus_out, 8'h0F);
        op(1'b0, 1'b1, 4'd9, 8'h22);
        chk("idle_hold_2", data_bus_out, 8'h0F);
        op(1'b0, 1'b0, 4'd3, 8'h33);
        chk("idle_hold_3", data_bus_out, 8'h0F);
        op(1'b1, 1'b1, 4'd3, 8'h00);
        chk("readback_3", data_bus_out, 8'hA5);

        for (int i = 0; i < 16; i++) begin
            op(1'b1, 1'b0, 4'(i), 8'(i * 17));
        end
        for (int i = 0; i < 16; i++) begin
            op(1'b1, 1'b1, 4'(i), 8'h00);
            chk($sformatf("sweep_rd%0d", i), data_bus_out, 8'(i * 17));
        end

        op(1'b1, 1'b0, 4'd7, 8'h3C);
        op(1'b1, 1'b1, 4'd7, 8'h00);
        chk("readback_7", data_bus_out, 8'h3C);

        // Reset arrives while a read of addr 7 is pending.
        mem_enable  = 1'b1;
        read_write  = 1'b1;
        address_bus = 4'd7;
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_during_read", data_bus_out, 8'h00);
        @(posedge clk);
        #1;
        chk("reset_held_edge", data_bus_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        op(1'b1, 1'b1, 4'd7, 8'h00);
        chk("read7_after_reset", data_bus_out, 8'h00);
        op(1'b1, 1'b1, 4'd15, 8'h00);
        chk("read15_after_reset", data_bus_out, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_memory_unit
